// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode values, one-hot bit positions and the
// helpers that classify an opcode's destination behaviour.
package decode_pkg;

  localparam int OP_W = 16;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_LI   = 6'd2;
  localparam logic [5:0] OP_SHL  = 6'd3;
  localparam logic [5:0] OP_SHR  = 6'd4;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_XOR  = 6'd7;
  localparam logic [5:0] OP_BEQ  = 6'd8;
  localparam logic [5:0] OP_BNE  = 6'd9;
  localparam logic [5:0] OP_MOV  = 6'd10;
  localparam logic [5:0] OP_ADDI = 6'd11;
  localparam logic [5:0] OP_MUL  = 6'd12;
  localparam logic [5:0] OP_HALT = 6'd13;
  localparam logic [5:0] OP_NOP  = 6'd14;

  localparam int BIT_ADD  = 0;
  localparam int BIT_SUB  = 1;
  localparam int BIT_LI   = 2;
  localparam int BIT_SHL  = 3;
  localparam int BIT_SHR  = 4;
  localparam int BIT_AND  = 5;
  localparam int BIT_OR   = 6;
  localparam int BIT_XOR  = 7;
  localparam int BIT_BEQ  = 8;
  localparam int BIT_BNE  = 9;
  localparam int BIT_MOV  = 10;
  localparam int BIT_ADDI = 11;
  localparam int BIT_MUL  = 12;
  localparam int BIT_HALT = 13;
  localparam int BIT_NOP  = 14;

  localparam logic [OP_W-1:0] OP_ONEHOT_NOP = 16'h4000;

  // Whether an opcode writes a register, and whether that register is rt (else rd).
  typedef struct packed {
    logic wr;
    logic use_rt;
  } dst_info_t;

  function automatic dst_info_t dst_info(input logic [5:0] op);
    dst_info_t d;
    d.wr     = 1'b0;
    d.use_rt = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_AND,
      OP_OR, OP_XOR, OP_MOV, OP_MUL: d.wr = 1'b1;
      OP_LI, OP_ADDI: begin
        d.wr     = 1'b1;
        d.use_rt = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

  // Opcodes 0..14 map straight onto their bit; anything else is a NOP.
  function automatic logic [OP_W-1:0] op_onehot(input logic [5:0] op);
    logic [OP_W-1:0] oh;
    oh = '0;
    if (op <= OP_NOP) oh[op[3:0]] = 1'b1;
    else              oh[BIT_NOP] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file: two combinational read ports, one write port,
// and write-through so a same-cycle write-back is visible to the reader.
module regfile_bypass #(
  parameter  int DATA_W  = 32,
  parameter  int REG_CNT = 32,
  localparam int RA_W    = $clog2(REG_CNT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [RA_W-1:0]   raddr_a,
  input  logic [RA_W-1:0]   raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // Reset clears every register and swallows any write arriving in that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rdata_a = (wr_en && (wr_addr == raddr_a)) ? wr_data : regs[raddr_a];
  assign rdata_b = (wr_en && (wr_addr == raddr_b)) ? wr_data : regs[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: register file, busy scoreboard with RAW interlock,
// a one-entry output register toward execute, branch flush and halt latching.
module decode_stage
  import decode_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int PC_W    = 32,
  parameter  int REG_CNT = 32,
  localparam int RA_W    = $clog2(REG_CNT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [PC_W-1:0]   ex_pc,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [RA_W-1:0]   ex_dst,
  output logic              ex_wr,
  output logic [DATA_W-1:0] ex_imm,
  output logic              halted
);

  logic [5:0]         op;
  logic [RA_W-1:0]    rs;
  logic [RA_W-1:0]    rt;
  logic [RA_W-1:0]    rd;
  logic [15:0]        imm;
  dst_info_t          info;
  logic [DATA_W-1:0]  rs_val;
  logic [DATA_W-1:0]  rt_val;
  logic [REG_CNT-1:0] busy;
  logic [REG_CNT-1:0] busy_next;
  logic               rs_hazard;
  logic               rt_hazard;
  logic               stall;
  logic               issue;
  logic               accept;

  assign op   = if_instr[31:26];
  assign rs   = if_instr[21 +: RA_W];
  assign rt   = if_instr[16 +: RA_W];
  assign rd   = if_instr[11 +: RA_W];
  assign imm  = if_instr[15:0];
  assign info = dst_info(op);

  regfile_bypass #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val)
  );

  // A source is unsafe if it is busy and not being written back right now, or
  // if the instruction sitting in the output register (issuing or not) will
  // write it: its busy bit is not set yet, so the scoreboard alone misses it.
  assign rs_hazard = (busy[rs] && !(wb_en && (wb_addr == rs))) ||
                     (ex_valid && ex_wr && (ex_dst == rs));
  assign rt_hazard = (busy[rt] && !(wb_en && (wb_addr == rt))) ||
                     (ex_valid && ex_wr && (ex_dst == rt));
  assign stall     = rs_hazard || rt_hazard;

  assign issue    = ex_valid && ex_ready;
  assign if_ready = !reset && !halted && !stall && (!ex_valid || ex_ready);
  assign accept   = if_valid && if_ready;

  // Scoreboard update: clear on write-back, then set on issue so set wins.
  always_comb begin
    busy_next = busy;
    if (wb_en)          busy_next[wb_addr] = 1'b0;
    if (issue && ex_wr) busy_next[ex_dst]  = 1'b1;
  end

  // Busy register; flush leaves it alone because nothing killed has issued.
  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  // Output register: flush beats accept, and a stalled consumer freezes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_op    <= OP_ONEHOT_NOP;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_dst   <= '0;
      ex_wr    <= 1'b0;
      ex_imm   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_pc    <= if_pc;
      ex_op    <= op_onehot(op);
      ex_a     <= rs_val;
      ex_b     <= rt_val;
      ex_dst   <= info.use_rt ? rt : rd;
      ex_wr    <= info.wr;
      ex_imm   <= {{(DATA_W-16){imm[15]}}, imm};
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Halt latches once a HALT actually leaves for execute and stays until reset.
  always_ff @(posedge clock) begin
    if (reset)                        halted <= 1'b0;
    else if (issue && ex_op[BIT_HALT]) halted <= 1'b1;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected issues, a
// monitor pops and compares whenever execute consumes an instruction.
module tb_decode_stage;

  logic        clock;
  logic        reset;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [15:0] ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [4:0]  ex_dst;
  logic        ex_wr;
  logic [31:0] ex_imm;
  logic        halted;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        wr;
    logic [31:0] imm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;
  int   waited;

  decode_stage #(
    .DATA_W  (32),
    .PC_W    (32),
    .REG_CNT (32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .flush    (flush),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_pc    (ex_pc),
    .ex_op    (ex_op),
    .ex_a     (ex_a),
    .ex_b     (ex_b),
    .ex_dst   (ex_dst),
    .ex_wr    (ex_wr),
    .ex_imm   (ex_imm),
    .halted   (halted)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] r_instr(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] pc, input logic [15:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] dst, input logic wr,
                                  input logic [31:0] imm);
    exp_t e;
    e.pc = pc; e.op = op; e.a = a; e.b = b; e.dst = dst; e.wr = wr; e.imm = imm;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one instruction until decode takes it; push its expected issue on acceptance.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input exp_t e, output int wait_cycles);
    bit got;
    got         = 1'b0;
    wait_cycles = 0;
    if_instr    = instr;
    if_pc       = pc;
    if_valid    = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      if (if_ready) begin
        sb_q.push_back(e);
        got = 1'b1;
      end else begin
        wait_cycles++;
      end
      tick();
    end
    if_valid = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: pc %0h never accepted, required accept within 20 cycles", pc);
    end
  endtask

  // Monitor: every consumed instruction must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && ex_valid && ex_ready) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_issue: got pc %0h op %0h, expected no instruction", ex_pc, ex_op);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("ex_pc",  64'(ex_pc),  64'(mon_e.pc));
        checkOutput("ex_op",  64'(ex_op),  64'(mon_e.op));
        checkOutput("ex_a",   64'(ex_a),   64'(mon_e.a));
        checkOutput("ex_b",   64'(ex_b),   64'(mon_e.b));
        checkOutput("ex_wr",  64'(ex_wr),  64'(mon_e.wr));
        checkOutput("ex_imm", 64'(ex_imm), 64'(mon_e.imm));
        if (mon_e.wr) checkOutput("ex_dst", 64'(ex_dst), 64'(mon_e.dst));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    if_valid    = 1'b0;
    if_instr    = '0;
    if_pc       = '0;
    wb_en       = 1'b1;
    wb_addr     = 5'd7;
    wb_data     = 32'h55;
    flush       = 1'b0;
    ex_ready    = 1'b1;

    repeat (2) tick();
    @(negedge clock);
    checkOutput("rst_ex_valid", 64'(ex_valid), 64'(0));
    checkOutput("rst_ex_op",    64'(ex_op),    64'(16'h4000));
    checkOutput("rst_ex_wr",    64'(ex_wr),    64'(0));
    checkOutput("rst_halted",   64'(halted),   64'(0));
    checkOutput("rst_if_ready", 64'(if_ready), 64'(0));
    checkOutput("rst_ex_pc",    64'(ex_pc),    64'(0));
    tick();

    reset   = 1'b0;
    wb_addr = 5'd1; wb_data = 32'd1;
    tick();
    wb_addr = 5'd2; wb_data = 32'd2;
    tick();
    wb_en = 1'b0;

    // ADD r3,r1,r2 then ADDI r5 <- r7 + -2 back to back (r7 write was lost to reset).
    applyStimulus(r_instr(6'd0, 5'd1, 5'd2, 5'd3), 32'h100,
                  mk_exp(32'h100, 16'h0001, 32'd1, 32'd2, 5'd3, 1'b1, 32'h1800), waited);
    checkOutput("add_wait", 64'(waited), 64'(0));
    applyStimulus(i_instr(6'd11, 5'd7, 5'd5, 16'hFFFE), 32'h104,
                  mk_exp(32'h104, 16'h0800, 32'd0, 32'd0, 5'd5, 1'b1, 32'hFFFF_FFFE), waited);
    checkOutput("addi_back_to_back", 64'(waited), 64'(0));

    // RAW: ADD r4 then ADD r6,r4,r1 must wait for the r4 write-back and see it bypassed.
    applyStimulus(r_instr(6'd0, 5'd1, 5'd2, 5'd4), 32'h108,
                  mk_exp(32'h108, 16'h0001, 32'd1, 32'd2, 5'd4, 1'b1, 32'h2000), waited);
    if_instr = r_instr(6'd0, 5'd4, 5'd1, 5'd6);
    if_pc    = 32'h10C;
    if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("raw_stall_if_ready", 64'(if_ready), 64'(0));
      tick();
    end
    wb_en   = 1'b1;
    wb_addr = 5'd4;
    wb_data = 32'hABCD;
    @(negedge clock);
    checkOutput("raw_release_if_ready", 64'(if_ready), 64'(1));
    if (if_ready) sb_q.push_back(mk_exp(32'h10C, 16'h0001, 32'hABCD, 32'd1, 5'd6, 1'b1, 32'h3000));
    tick();
    wb_en    = 1'b0;
    if_valid = 1'b0;

    // Backpressure: ADD r6 held for 3 cycles with XOR r9 waiting behind it.
    ex_ready = 1'b0;
    if_instr = r_instr(6'd7, 5'd1, 5'd2, 5'd9);
    if_pc    = 32'h110;
    if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("bp_if_ready", 64'(if_ready), 64'(0));
      checkOutput("bp_ex_valid", 64'(ex_valid), 64'(1));
      checkOutput("bp_ex_pc",    64'(ex_pc),    64'(32'h10C));
      checkOutput("bp_ex_a",     64'(ex_a),     64'(32'hABCD));
      checkOutput("bp_ex_dst",   64'(ex_dst),   64'(6));
      tick();
    end
    ex_ready = 1'b1;
    applyStimulus(r_instr(6'd7, 5'd1, 5'd2, 5'd9), 32'h110,
                  mk_exp(32'h110, 16'h0080, 32'd1, 32'd2, 5'd9, 1'b1, 32'h4800), waited);
    checkOutput("bp_resume_wait", 64'(waited), 64'(0));

    // Flush: OR issues, the SUB offered in the flush cycle must vanish.
    applyStimulus(r_instr(6'd6, 5'd1, 5'd2, 5'd10), 32'h114,
                  mk_exp(32'h114, 16'h0040, 32'd1, 32'd2, 5'd10, 1'b1, 32'h5000), waited);
    if_instr = r_instr(6'd1, 5'd1, 5'd2, 5'd11);
    if_pc    = 32'h118;
    if_valid = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    @(negedge clock);
    checkOutput("flush_ex_valid", 64'(ex_valid), 64'(0));
    repeat (2) tick();

    // Unknown opcode 63 decodes as NOP without a write.
    applyStimulus(r_instr(6'd63, 5'd1, 5'd2, 5'd12), 32'h11C,
                  mk_exp(32'h11C, 16'h4000, 32'd1, 32'd2, 5'd0, 1'b0, 32'h6000), waited);

    // HALT issues, then decode refuses everything.
    applyStimulus(r_instr(6'd13, 5'd0, 5'd0, 5'd0), 32'h120,
                  mk_exp(32'h120, 16'h2000, 32'd0, 32'd0, 5'd0, 1'b0, 32'h0), waited);
    tick();
    if_instr = r_instr(6'd0, 5'd1, 5'd2, 5'd14);
    if_pc    = 32'h124;
    if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("halt_halted",   64'(halted),   64'(1));
      checkOutput("halt_if_ready", 64'(if_ready), 64'(0));
      tick();
    end

    // Reset while an instruction reading busy r3 waits; write-back in that cycle is lost.
    if_instr = r_instr(6'd0, 5'd2, 5'd3, 5'd13);
    reset    = 1'b1;
    wb_en    = 1'b1;
    wb_addr  = 5'd2;
    wb_data  = 32'h99;
    @(negedge clock);
    checkOutput("mid_rst_if_ready", 64'(if_ready), 64'(0));
    tick();
    reset    = 1'b0;
    wb_en    = 1'b0;
    if_valid = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_halted",   64'(halted),   64'(0));
    checkOutput("post_rst_ex_valid", 64'(ex_valid), 64'(0));
    checkOutput("post_rst_ex_op",    64'(ex_op),    64'(16'h4000));
    tick();
    applyStimulus(r_instr(6'd0, 5'd2, 5'd3, 5'd13), 32'h128,
                  mk_exp(32'h128, 16'h0001, 32'd0, 32'd0, 5'd13, 1'b1, 32'h6800), waited);
    checkOutput("post_rst_no_stall", 64'(waited), 64'(0));

    repeat (3) tick();
    checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
